// File: rtl/pipeline_issue_ctrl.sv
// Issue controller: owns the PC and fetch handshake, tracks outstanding
// register writes in a per-register scoreboard, stalls decode on RAW hazards
// and on write-count saturation, and turns branch redirects into a
// one-cycle flush.
module pipeline_issue_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              NUM_REGS     = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              PC_STEP      = 4,
    parameter int              MAX_PER_REG  = 3,
    parameter int              MAX_INFLIGHT = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    output logic                              fetch_en,
    output logic [XLEN-1:0]                   fetch_addr,
    input  logic                              fetch_ready,
    input  logic                              issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0]       issue_rs1,
    input  logic                              issue_rs1_used,
    input  logic [$clog2(NUM_REGS)-1:0]       issue_rs2,
    input  logic                              issue_rs2_used,
    input  logic [$clog2(NUM_REGS)-1:0]       issue_rd,
    input  logic                              issue_rd_wr,
    output logic                              issue_stall,
    output logic                              issue_fire,
    input  logic                              wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0]       wb_rd,
    input  logic                              redirect_valid,
    input  logic [XLEN-1:0]                   redirect_pc,
    output logic                              flush,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              sb_error
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MAX_PER_REG + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    logic [XLEN-1:0]              pc;
    logic [NUM_REGS-1:0][CW-1:0]  cnt;
    logic [NUM_REGS-1:0][CW-1:0]  cnt_nxt;
    logic [IW-1:0]                inflight_q;
    logic [IW-1:0]                inflight_nxt;
    logic                         flush_q;
    logic                         err_q;
    logic                         hazard;
    logic                         inc;
    logic                         dec;
    logic                         err_set;

    // Hazard detection looks only at registered counters: a writeback in the
    // same cycle does not unstall, so a dependent always sees a bubble.
    always_comb begin
        hazard = 1'b0;
        if (issue_rs1_used && issue_rs1 != '0 && cnt[issue_rs1] != '0)
            hazard = 1'b1;
        if (issue_rs2_used && issue_rs2 != '0 && cnt[issue_rs2] != '0)
            hazard = 1'b1;
        if (issue_rd_wr && issue_rd != '0 && cnt[issue_rd] == CW'(MAX_PER_REG))
            hazard = 1'b1;
        if (issue_rd_wr && issue_rd != '0 && inflight_q == IW'(MAX_INFLIGHT))
            hazard = 1'b1;
    end

    assign issue_stall = issue_valid & hazard;
    assign issue_fire  = issue_valid & ~hazard & ~redirect_valid & ~flush_q;
    assign fetch_en    = reset_n & ~issue_stall & ~flush_q;
    assign fetch_addr  = pc;
    assign flush       = flush_q;
    assign inflight    = inflight_q;
    assign sb_error    = err_q;

    assign inc     = issue_fire & issue_rd_wr & (issue_rd != '0);
    assign dec     = wb_valid & (wb_rd != '0) & (cnt[wb_rd] != '0);
    assign err_set = wb_valid & (wb_rd != '0) & (cnt[wb_rd] == '0);

    // Next scoreboard state; an inc and dec on the same register cancel.
    // Register 0 never moves because inc/dec both exclude it.
    always_comb begin
        cnt_nxt = cnt;
        if (inc) cnt_nxt[issue_rd] = cnt_nxt[issue_rd] + CW'(1);
        if (dec) cnt_nxt[wb_rd]    = cnt_nxt[wb_rd] - CW'(1);
        case ({inc, dec})
            2'b10:   inflight_nxt = inflight_q + IW'(1);
            2'b01:   inflight_nxt = inflight_q - IW'(1);
            default: inflight_nxt = inflight_q;
        endcase
    end

    // State update: redirect beats sequential fetch; error flag is sticky.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            cnt        <= '0;
            inflight_q <= '0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            inflight_q <= inflight_nxt;
            flush_q    <= redirect_valid;
            if (err_set) err_q <= 1'b1;
            if (redirect_valid)
                pc <= redirect_pc & ~XLEN'(3);
            else if (fetch_en && fetch_ready)
                pc <= pc + XLEN'(PC_STEP);
        end
    end

    logic unused_rw;
    assign unused_rw = (RW == 0);
endmodule

// File: doc/pipeline_issue_ctrl.md
Name: pipeline_issue_ctrl

Overview:
- Parametrised successor to the fixed-step PC/pipeline control inside the execution unit.
- Owns the program counter and fetch handshake. Tracks in-flight register writes in a per-register scoreboard and stalls issue on RAW/WAW-saturation hazards.
- Handles branch redirects with a one-cycle flush pulse.
- Sits between fetch, decode and writeback. Decode presents one instruction per cycle; writeback reports retirements.

Parameters:
- XLEN, 32, width of PC and redirect address.
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero and never tracked.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per accepted fetch.
- MAX_PER_REG, 3, max outstanding writes to one register.
- MAX_INFLIGHT, 4, max outstanding writes in total.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- fetch_en  out  1  fetch request valid
- fetch_addr  out  XLEN  fetch address (= pc)
- fetch_ready  in  1  memory accepts request this cycle
- issue_valid  in  1  decode has an instruction to issue
- issue_rs1  in  $clog2(NUM_REGS)  source 1 index
- issue_rs1_used  in  1  source 1 is read
- issue_rs2  in  $clog2(NUM_REGS)  source 2 index
- issue_rs2_used  in  1  source 2 is read
- issue_rd  in  $clog2(NUM_REGS)  destination index
- issue_rd_wr  in  1  instruction writes rd
- issue_stall  out  1  decode must hold its instruction
- issue_fire  out  1  instruction accepted this cycle
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  $clog2(NUM_REGS)  retired destination
- redirect_valid  in  1  taken branch/jump
- redirect_pc  in  XLEN  branch target
- flush  out  1  squash fetch/decode contents
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding write count
- sb_error  out  1  sticky: writeback to an untracked register

Behaviour:
- One clock; reset is synchronous and active-low (clk, reset_n).
- Reset cycle:
  - pc=RESET_PC, all scoreboard counters 0, inflight=0, flush=0, sb_error=0.
  - fetch_en=0 while reset_n=0.
- Scoreboard: cnt[r], width $clog2(MAX_PER_REG+1), for r=1..NUM_REGS-1.
- hazard (combinational, from registered counters only; no same-cycle writeback bypass):
  - (rs1_used & rs1!=0 & cnt[rs1]!=0), or
  - (rs2_used & rs2!=0 & cnt[rs2]!=0), or
  - (rd_wr & rd!=0 & cnt[rd]==MAX_PER_REG), or
  - (rd_wr & rd!=0 & inflight==MAX_INFLIGHT).
- issue_stall = issue_valid & hazard.
- issue_fire = issue_valid & !hazard & !redirect_valid & !flush.
- Counter update per cycle:
  - inc = issue_fire & rd_wr & rd!=0.
  - dec = wb_valid & wb_rd!=0 & cnt[wb_rd]!=0.
  - Same register inc and dec in one cycle: counter unchanged. inflight follows the same net rule.
- wb_valid with wb_rd=0: ignored.
- wb_valid with cnt[wb_rd]==0: no decrement; sb_error set and held until reset.
- fetch_en = reset_n & !issue_stall & !flush.
- PC update, priority order:
  1. redirect_valid: pc <= {redirect_pc[XLEN-1:2],2'b00}; flush <= 1 next cycle for exactly one cycle.
  2. fetch_en & fetch_ready: pc <= pc+PC_STEP, wraps modulo 2^XLEN.
  3. Otherwise pc holds.
- Redirect does not clear the scoreboard; already-issued writes still retire.
- Redirect during flush cycle: new target taken; flush extends one more cycle.
- Redirect and stall in the same cycle: redirect wins; issue_fire=0.
- fetch_ready low: pc and fetch_addr held stable, fetch_en stays asserted.
- reset_n low mid-operation: all state returns to reset values the next edge; inputs ignored that cycle.
- Latency:
  - issue_fire → dependent source unstalled on the cycle after the matching wb_valid edge (minimum 1-cycle bubble).
  - redirect → fetch_addr=target next cycle.

Test Plan:
- Reset, fetch_ready=1 for 4 cycles → fetch_addr 0x0,0x4,0x8,0xC; inflight=0; flush=0.
- Issue rd=5 write; next cycle issue rs1=5 → issue_stall=1, fetch_en=0. wb_valid rd=5 → stall drops the following cycle; cnt[5]=0.
- Issue 3 writes to rd=7 (MAX_PER_REG=3), then a 4th → 4th stalls. Same-cycle wb rd=7 with 4th issue → still stalled this cycle, fires next; cnt[7]=3.
- Issue writes to r1..r4, then r6 → inflight=4, r6 stalls. Issue rd=0 → fires, inflight stays 4.
- pc=0x100, redirect_valid with redirect_pc=0x2003 and issue_valid=1 → issue_fire=0; next cycle fetch_addr=0x2000, flush=1 for one cycle; scoreboard unchanged.
- wb_valid rd=9 with cnt[9]=0 → sb_error=1 and stays 1; reset_n=0 one cycle → sb_error=0, pc=RESET_PC. pc=0xFFFFFFFC with fetch → 0x0.
